// File: rtl/sudoku_mask_unpack_if.sv
// Per-cell record stream from the mask reader to the solution writer.
// The master holds the record stable while cell_valid is high and cell_ready is low.
interface sudoku_mask_unpack_if;
    logic       cell_valid;
    logic       cell_ready;
    logic [3:0] cell_x;
    logic [3:0] cell_y;
    logic [3:0] cell_digit;
    logic [1:0] cell_status;

    modport master (
        output cell_valid, cell_x, cell_y, cell_digit, cell_status,
        input  cell_ready
    );

    modport slave (
        input  cell_valid, cell_x, cell_y, cell_digit, cell_status,
        output cell_ready
    );
endinterface

// File: rtl/sudoku_mask_unpack.sv
// Walks a captured 729-bit candidate mask cell by cell and classifies each cell.
// First record one cycle after start, one cell per cycle; a stalled record holds until cell_ready.
module sudoku_mask_unpack #(
    parameter bit EMIT_ALL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [728:0]         puzzle_mask_bin,
    output logic                 busy,
    output logic                 done,
    output logic [6:0]           solved_count,
    output logic [6:0]           contra_count,
    sudoku_mask_unpack_if.master rec
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [1:0] ST_SINGLE = 2'b00;
    localparam logic [1:0] ST_MULTI  = 2'b01;
    localparam logic [1:0] ST_CONTRA = 2'b10;

    state_t       state, state_nxt;
    logic [728:0] mask_q;
    logic [6:0]   cell_idx;
    logic [3:0]   x_q, y_q;
    logic [3:0]   clear_cnt;
    logic [3:0]   clear_idx;
    logic [1:0]   status;
    logic         emit;
    logic         advance;
    logic         last_cell;

    // The mask is shifted down after every cell, so the current cell is always bits [8:0].
    always_comb begin
        clear_cnt = '0;
        clear_idx = '0;
        for (int i = 0; i < 9; i++) begin
            if (!mask_q[i]) begin
                clear_cnt = clear_cnt + 4'd1;
                clear_idx = 4'(i);
            end
        end
        if (clear_cnt == 4'd0)
            status = ST_CONTRA;
        else if (clear_cnt == 4'd1)
            status = ST_SINGLE;
        else
            status = ST_MULTI;
    end

    assign emit      = (state == SCAN) && (EMIT_ALL || (status == ST_SINGLE));
    assign advance   = (state == SCAN) && (!emit || rec.cell_ready);
    assign last_cell = (cell_idx == 7'd80);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (advance && last_cell) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy            = (state != IDLE);
        done            = (state == DONE);
        rec.cell_valid  = emit;
        rec.cell_x      = emit ? x_q : 4'd0;
        rec.cell_y      = emit ? y_q : 4'd0;
        rec.cell_status = emit ? status : 2'b00;
        rec.cell_digit  = (emit && status == ST_SINGLE) ? clear_idx + 4'd1 : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q       <= '0;
            cell_idx     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            solved_count <= '0;
            contra_count <= '0;
        end else if (state == IDLE && start) begin
            mask_q       <= puzzle_mask_bin;
            cell_idx     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            solved_count <= '0;
            contra_count <= '0;
        end else if (advance) begin
            if (status == ST_SINGLE)
                solved_count <= solved_count + 7'd1;
            if (status == ST_CONTRA)
                contra_count <= contra_count + 7'd1;
            // Cell 80 is terminal: the index parks there instead of wrapping.
            if (!last_cell) begin
                mask_q   <= {9'd0, mask_q[728:9]};
                cell_idx <= cell_idx + 7'd1;
                if (y_q == 4'd8) begin
                    y_q <= 4'd0;
                    x_q <= x_q + 4'd1;
                end else begin
                    y_q <= y_q + 4'd1;
                end
            end
        end
    end
endmodule
